// File: rtl/apb_slv_tmo_pkg.sv
// State encoding and register bundle for the APB slave front-end with watchdog.
package apb_slv_tmo_pkg;

    typedef enum logic [1:0] {
        State_Idle,
        State_Request,
        State_WaitResp,
        State_Resp
    } apb_slv_tmo_state_e;

    // Parameter-width fields (local address, watchdog timer) are kept in the module.
    typedef struct packed {
        apb_slv_tmo_state_e state;
        logic               req_valid;
        logic               write;
        logic [31:0]        wdata;
        logic [3:0]         wstrb;
        logic               pready;
        logic [31:0]        prdata;
        logic               pslverr;
        logic               tmo;
    } apb_slv_tmo_registers;

    localparam apb_slv_tmo_registers apb_slv_tmo_r_reset = '{
        State_Idle, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0
    };

endpackage

// File: rtl/types_amba_pkg.sv
// Shared AMBA/APB bus types and plug-and-play descriptor definitions.
package types_amba_pkg;

    localparam logic [7:0] PNP_CFG_DEV_DESCR_BYTES = 8'h10;
    localparam logic [1:0] PNP_CFG_TYPE_SLAVE      = 2'b10;

    typedef struct packed {
        logic [31:0] addr_start;
        logic [31:0] addr_end;
    } mapinfo_type;

    typedef struct packed {
        logic [7:0]  descrsize;
        logic [1:0]  descrtype;
        logic [31:0] addr_start;
        logic [31:0] addr_end;
        logic [15:0] vid;
        logic [15:0] did;
    } dev_config_type;

    typedef struct packed {
        logic        pselx;
        logic        penable;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;

endpackage

// File: rtl/apb_slv_tmo.sv
// APB3/APB4 slave front-end: turns APB accesses into a valid/ready request and
// a single-strobe response, completing hung accesses with PSLVERR via a watchdog.
module apb_slv_tmo
    import types_amba_pkg::*;
    import apb_slv_tmo_pkg::*;
#(
    parameter logic [15:0] vid        = 16'h0000,
    parameter logic [15:0] did        = 16'h0000,
    parameter int unsigned abits      = 12,
    parameter int unsigned tmo_cycles = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  mapinfo_type          i_mapinfo,
    output dev_config_type       o_cfg,
    input  apb_in_type           i_apbi,
    output apb_out_type          o_apbo,
    output logic                 o_req_valid,
    input  logic                 i_req_ready,
    output logic [abits-1:0]     o_req_addr,
    output logic                 o_req_write,
    output logic [31:0]          o_req_wdata,
    output logic [3:0]           o_req_wstrb,
    input  logic                 i_resp_valid,
    input  logic [31:0]          i_resp_rdata,
    input  logic                 i_resp_err,
    output logic                 o_tmo
);

    localparam int unsigned    TW     = (tmo_cycles == 0) ? 1 : $clog2(tmo_cycles + 1);
    localparam bit             TMO_EN = (tmo_cycles != 0);
    localparam logic [TW-1:0]  TLAST  = TW'((tmo_cycles == 0) ? 0 : tmo_cycles - 1);
    localparam logic [TW-1:0]  TMAX   = '1;

    apb_slv_tmo_registers r_q, r_d;
    logic [abits-1:0]     addr_q, addr_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 busy;
    logic                 resp_take;
    logic                 expire;

    assign busy = (r_q.state == State_Request) || (r_q.state == State_WaitResp);

    // In Request a response only counts when it coincides with acceptance.
    assign resp_take = ((r_q.state == State_WaitResp) && i_resp_valid) ||
                       ((r_q.state == State_Request) && i_req_ready && i_resp_valid);

    assign expire = TMO_EN && busy && (timer_q == TLAST) && !resp_take;

    always_comb begin
        r_d     = r_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        r_d.tmo = 1'b0;

        unique case (r_q.state)
            State_Idle: begin
                r_d.pready  = 1'b0;
                r_d.pslverr = 1'b0;
                if (i_apbi.pselx) begin
                    r_d.state     = State_Request;
                    r_d.req_valid = 1'b1;
                    addr_d        = abits'(i_apbi.paddr - i_mapinfo.addr_start);
                    r_d.write     = i_apbi.pwrite;
                    r_d.wdata     = i_apbi.pwdata;
                    r_d.wstrb     = i_apbi.pwrite ? i_apbi.pstrb : 4'hF;
                    timer_d       = '0;
                end
            end
            State_Request, State_WaitResp: begin
                timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
                if (resp_take) begin
                    r_d.state     = State_Resp;
                    r_d.req_valid = 1'b0;
                    r_d.pready    = 1'b1;
                    r_d.prdata    = i_resp_rdata;
                    r_d.pslverr   = i_resp_err;
                end else if (expire) begin
                    r_d.state     = State_Resp;
                    r_d.req_valid = 1'b0;
                    r_d.pready    = 1'b1;
                    r_d.prdata    = 32'h0;
                    r_d.pslverr   = 1'b1;
                    r_d.tmo       = 1'b1;
                end else if ((r_q.state == State_Request) && i_req_ready) begin
                    r_d.state     = State_WaitResp;
                    r_d.req_valid = 1'b0;
                end
            end
            State_Resp: begin
                // A master that has already dropped PSELx gets its response discarded.
                if (i_apbi.penable || !i_apbi.pselx) begin
                    r_d.state   = State_Idle;
                    r_d.pready  = 1'b0;
                    r_d.pslverr = 1'b0;
                end
            end
            default: r_d.state = State_Idle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_q     <= apb_slv_tmo_r_reset;
            addr_q  <= '0;
            timer_q <= '0;
        end else begin
            r_q     <= r_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
        end
    end

    assign o_cfg.descrsize  = PNP_CFG_DEV_DESCR_BYTES;
    assign o_cfg.descrtype  = PNP_CFG_TYPE_SLAVE;
    assign o_cfg.addr_start = i_mapinfo.addr_start;
    assign o_cfg.addr_end   = i_mapinfo.addr_end;
    assign o_cfg.vid        = vid;
    assign o_cfg.did        = did;

    assign o_apbo.pready  = r_q.pready;
    assign o_apbo.prdata  = r_q.prdata;
    assign o_apbo.pslverr = r_q.pslverr;

    assign o_req_valid = r_q.req_valid;
    assign o_req_addr  = addr_q;
    assign o_req_write = r_q.write;
    assign o_req_wdata = r_q.wdata;
    assign o_req_wstrb = r_q.wstrb;
    assign o_tmo       = r_q.tmo;

endmodule
